// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample SRAM sequencer: FSM state
// encoding, default widths and the maximum-address helper.
// Optional build macro used by audio_sram_ctrl: AUDIO_SRAM_CTRL_LOOP_EN.
package audio_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 8;

    // State encoding is visible on the debug/LED port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REC_WAIT  = 3'd1,
        ST_REC_WR    = 3'd2,
        ST_PLAY_WAIT = 3'd3,
        ST_PLAY_RD   = 3'd4,
        ST_PAUSE     = 3'd5
    } state_e;

    // Highest word address for a given address width.
    function automatic logic [31:0] max_addr(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam logic [31:0] MAX_ADDR = max_addr(ADDR_W_DEF);

endpackage

// File: rtl/sram_access_timer.sv
// Down-counter that times one SRAM access. Loaded on the edge that enters
// the access state; last_cycle_o is high during the final access cycle.
module sram_access_timer
    import audio_pkg::*;
(
    input  logic             bclk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_cycle_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load the access length, then count down to zero and stay there.
    always_ff @(posedge bclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_cycle_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/audio_sram_ctrl.sv
// Record/playback sequencer for the shared audio sample SRAM.
// Build option: define AUDIO_SRAM_CTRL_LOOP_EN to loop playback at the end
// of the recording instead of returning to IDLE.
module audio_sram_ctrl
    import audio_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              bclk,
    input  logic              reset,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic              full,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(max_addr(ADDR_W));
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rec_len_q;
    logic [DATA_W-1:0] dac_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              dq_oe_q, ce_n_q, we_n_q, oe_n_q;
    logic              full_q, overrun_q;
    logic              pause_pend_q, stop_pend_q;
    logic              resume_play_q;   // 1: PAUSE came from playback

    logic             start_wr, start_rd, timer_last;
    logic             stop_now, pause_now, play_end;
    logic [CNT_W-1:0] timer_val;
    logic [ADDR_W:0]  len_here;

    // Access starts and end-of-access decisions; commands outrank data strobes.
    always_comb begin
        start_wr  = (state_q == ST_REC_WAIT)  && !cmd_stop && !cmd_pause && adc_valid;
        start_rd  = (state_q == ST_PLAY_WAIT) && !cmd_stop && !cmd_pause && dac_req;
        timer_val = start_wr ? CNT_W'(WR_CYCLES) : CNT_W'(RD_CYCLES);
        stop_now  = stop_pend_q | cmd_stop;
        pause_now = pause_pend_q | cmd_pause;
        len_here  = {1'b0, addr_q} + LEN_ONE;
        play_end  = (len_here == rec_len_q);
    end

    sram_access_timer u_timer (
        .bclk         (bclk),
        .reset        (reset),
        .load_i       (start_wr | start_rd),
        .load_val_i   (timer_val),
        .last_cycle_o (timer_last)
    );

    // Main sequencer; every SRAM strobe is a register so it is glitch-free.
    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            rec_len_q     <= '0;
            dac_q         <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            ce_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            full_q        <= 1'b0;
            overrun_q     <= 1'b0;
            pause_pend_q  <= 1'b0;
            stop_pend_q   <= 1'b0;
            resume_play_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Also clears the final sample one cycle after playback ends.
                    dac_q <= '0;
                    if (!cmd_stop && !cmd_pause) begin
                        if (cmd_play) begin
                            if (rec_len_q != '0) begin
                                addr_q  <= '0;
                                state_q <= ST_PLAY_WAIT;
                            end
                        end else if (cmd_record) begin
                            addr_q    <= '0;
                            rec_len_q <= '0;
                            full_q    <= 1'b0;
                            overrun_q <= 1'b0;
                            state_q   <= ST_REC_WAIT;
                        end
                    end
                end
                ST_REC_WAIT: begin
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                    end else if (cmd_pause) begin
                        resume_play_q <= 1'b0;
                        state_q       <= ST_PAUSE;
                    end else if (adc_valid) begin
                        dq_out_q <= adc_data;
                        dq_oe_q  <= 1'b1;
                        ce_n_q   <= 1'b0;
                        we_n_q   <= 1'b0;
                        state_q  <= ST_REC_WR;
                    end
                end
                ST_REC_WR: begin
                    if (adc_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (timer_last) begin
                        ce_n_q       <= 1'b1;
                        we_n_q       <= 1'b1;
                        dq_oe_q      <= 1'b0;
                        rec_len_q    <= len_here;
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        if (addr_q == ADDR_MAX) begin
                            full_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (stop_now) begin
                                state_q <= ST_IDLE;
                            end else if (pause_now) begin
                                resume_play_q <= 1'b0;
                                state_q       <= ST_PAUSE;
                            end else begin
                                state_q <= ST_REC_WAIT;
                            end
                        end
                    end else begin
                        if (cmd_stop)  stop_pend_q  <= 1'b1;
                        if (cmd_pause) pause_pend_q <= 1'b1;
                    end
                end
                ST_PLAY_WAIT: begin
                    if (cmd_stop) begin
                        dac_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cmd_pause) begin
                        dac_q         <= '0;
                        resume_play_q <= 1'b1;
                        state_q       <= ST_PAUSE;
                    end else if (dac_req) begin
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        state_q <= ST_PLAY_RD;
                    end
                end
                ST_PLAY_RD: begin
                    if (timer_last) begin
                        // A completed read is always presented; IDLE/PAUSE clear it next cycle.
                        ce_n_q       <= 1'b1;
                        oe_n_q       <= 1'b1;
                        dac_q        <= sram_dq_in;
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        if (stop_now) begin
                            state_q <= ST_IDLE;
                        end else if (play_end) begin
`ifdef AUDIO_SRAM_CTRL_LOOP_EN
                            addr_q        <= '0;
                            resume_play_q <= 1'b1;
                            state_q       <= pause_now ? ST_PAUSE : ST_PLAY_WAIT;
`else
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            addr_q        <= addr_q + ADDR_W'(1);
                            resume_play_q <= 1'b1;
                            state_q       <= pause_now ? ST_PAUSE : ST_PLAY_WAIT;
                        end
                    end else begin
                        if (cmd_stop)  stop_pend_q  <= 1'b1;
                        if (cmd_pause) pause_pend_q <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (resume_play_q) begin
                        dac_q <= '0;
                    end
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                    end else if (cmd_pause) begin
                        state_q <= resume_play_q ? ST_PLAY_WAIT : ST_REC_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_data    = dac_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign state       = state_q;
    assign rec_len     = rec_len_q;
    assign full        = full_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Testbench for audio_sram_ctrl with a 16-word SRAM (ADDR_W=4) so the
// full-memory case is reachable. Honours AUDIO_SRAM_CTRL_LOOP_EN.
module tb_audio_sram_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int WR_CYC = 2;
    localparam int RD_CYC = 2;
    localparam int DEPTH = 1 << AW;

    localparam int C_REC = 0, C_PLAY = 1, C_PAUSE = 2, C_STOP = 3;

    logic          bclk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_record = 0, cmd_play = 0, cmd_pause = 0, cmd_stop = 0;
    logic          adc_valid = 0;
    logic [DW-1:0] adc_data = '0;
    logic          dac_req = 0;
    logic [DW-1:0] dac_data, sram_dq_out, sram_dq_in;
    logic [AW-1:0] sram_addr;
    logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
    logic [2:0]    state;
    logic [AW:0]   rec_len;
    logic          full, overrun;

    audio_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR_CYC), .RD_CYCLES(RD_CYC)) dut (
        .bclk(bclk), .reset(reset),
        .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req), .dac_data(dac_data),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .state(state), .rec_len(rec_len), .full(full), .overrun(overrun)
    );

    // ---------------- clock ----------------
    always #5 bclk = ~bclk;

    // ---------------- external SRAM model ----------------
    logic [DW-1:0] sram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'hDEAD;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: at the end of each strobe run, check its length and pop the expected access.
    int            wr_run = 0, rd_run = 0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_unstable, rd_unstable;
    logic [AW+DW-1:0] wexp;
    logic [DW-1:0]    rexp;
    always @(negedge bclk) begin
        if (reset) begin
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (!sram_we_n) begin
                if (wr_run == 0) begin
                    wr_addr = sram_addr;
                    wr_data = sram_dq_out;
                    wr_unstable = 1'b0;
                end
                if (sram_addr != wr_addr || sram_dq_out != wr_data || sram_ce_n || !sram_dq_oe || !sram_oe_n)
                    wr_unstable = 1'b1;
                wr_run++;
            end else if (wr_run > 0) begin
                check("wr_len", wr_run, WR_CYC);
                check("wr_stable", {31'd0, wr_unstable}, 0);
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    wexp = exp_wr_q.pop_front();
                    check("wr_addr", {28'd0, wr_addr}, {28'd0, wexp[AW+DW-1:DW]});
                    check("wr_data", {16'd0, wr_data}, {16'd0, wexp[DW-1:0]});
                end
                sram[wr_addr] = wr_data;
                wr_run = 0;
            end
            if (!sram_oe_n) begin
                if (rd_run == 0) rd_unstable = 1'b0;
                if (sram_ce_n || sram_dq_oe || !sram_we_n) rd_unstable = 1'b1;
                rd_run++;
            end else if (rd_run > 0) begin
                check("rd_len", rd_run, RD_CYC);
                check("rd_strobes", {31'd0, rd_unstable}, 0);
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    rexp = exp_rd_q.pop_front();
                    check("rd_dac_data", {16'd0, dac_data}, {16'd0, rexp});
                end
                rd_run = 0;
            end
        end
    end

    // ---------------- reference model (sample-level behaviour) ----------------
    logic [DW-1:0] model_mem [DEPTH];
    int model_len = 0, model_addr = 0, model_pos = 0;
    bit model_recording = 0, model_playing = 0;
`ifdef AUDIO_SRAM_CTRL_LOOP_EN
    bit model_loop = 1;
`else
    bit model_loop = 0;
`endif

    // ---------------- drivers (all tasks start and end on a falling edge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge bclk);
    endtask

    task automatic pulse_cmd(input int which);
        case (which)
            C_REC:   cmd_record = 1'b1;
            C_PLAY:  cmd_play   = 1'b1;
            C_PAUSE: cmd_pause  = 1'b1;
            default: cmd_stop   = 1'b1;
        endcase
        tick(1);
        cmd_record = 0; cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
    endtask

    task automatic pulse_adc(input logic [DW-1:0] d);
        adc_data = d;
        adc_valid = 1'b1;
        tick(1);
        adc_valid = 1'b0;
    endtask

    task automatic pulse_dac();
        dac_req = 1'b1;
        tick(1);
        dac_req = 1'b0;
    endtask

    task automatic do_record();
        pulse_cmd(C_REC);
        model_len = 0; model_addr = 0; model_recording = 1; model_playing = 0;
    endtask

    task automatic do_play();
        pulse_cmd(C_PLAY);
        if (model_len != 0) begin
            model_playing = 1;
            model_pos = 0;
        end
    endtask

    task automatic do_stop();
        pulse_cmd(C_STOP);
        model_recording = 0;
        model_playing = 0;
    endtask

    // Offer one sample; the model stores it at the next address while recording.
    task automatic record_sample(input logic [DW-1:0] d);
        if (model_recording) begin
            exp_wr_q.push_back({model_addr[AW-1:0], d});
            model_mem[model_addr] = d;
            model_len = model_addr + 1;
            if (model_addr == DEPTH - 1) model_recording = 0;
            else model_addr++;
        end
        pulse_adc(d);
    endtask

    // Request one sample; the model returns the recording in order.
    task automatic play_request();
        if (model_playing) begin
            exp_rd_q.push_back(model_mem[model_pos]);
            model_pos++;
            if (model_pos == model_len) begin
                if (model_loop) model_pos = 0;
                else model_playing = 0;
            end
        end
        pulse_dac();
    endtask

    function automatic logic [DW-1:0] rnd_sample();
        return DW'($urandom_range(1, 16'hFFFF));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        tick(4);
        reset = 1'b0;
        tick(1);
        check("rst_state", state, 0);
        check("rst_strobes", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b1110);
        check("rst_rec_len", rec_len, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_flags", {full, overrun}, 0);

        // play with nothing recorded is ignored
        do_play();
        tick(4);
        check("empty_play_state", state, 0);

        // record five samples, then stop
        do_record();
        for (int i = 0; i < 5; i++) begin
            record_sample(DW'(16'h1111 * (i + 1)));
            tick(63);
        end
        do_stop();
        tick(2);
        check("rec_stop_state", state, 0);
        check("rec_stop_len", rec_len, model_len);
        for (int i = 0; i < 5; i++) check("sram_content", sram[i], model_mem[i]);

        // playback with one request more than the recording
        do_play();
        tick(2);
        for (int i = 0; i < 6; i++) begin
            play_request();
            tick(8);
        end
        check("play_end_state", state, model_playing ? 3 : 0);
        if (model_playing) begin
            do_stop();
            tick(2);
            check("play_stop_state", state, 0);
        end
        check("play_end_dac", dac_data, 0);

        // overrun: second sample one cycle after the first is dropped
        do_record();
        record_sample(rnd_sample());
        pulse_adc(rnd_sample());
        tick(4);
        check("overrun_flag", overrun, 1);
        check("overrun_state", state, 1);
        do_stop();
        tick(2);
        check("overrun_len", rec_len, model_len);

        // pause issued during a write
        do_record();
        tick(1);
        check("record_clears_overrun", overrun, 0);
        for (int i = 0; i < 2; i++) begin
            record_sample(rnd_sample());
            tick(6);
        end
        record_sample(rnd_sample());
        pulse_cmd(C_PAUSE);
        model_recording = 0;
        tick(4);
        check("pause_state", state, 5);
        check("pause_addr", sram_addr, model_addr);
        check("pause_len", rec_len, model_len);
        pulse_adc(rnd_sample());
        tick(4);
        pulse_cmd(C_PAUSE);
        model_recording = 1;
        tick(1);
        check("resume_state", state, 1);
        record_sample(rnd_sample());
        tick(6);
        do_stop();
        tick(2);
        check("pause_final_len", rec_len, model_len);

        // fill the memory; the 17th sample is ignored
        do_record();
        for (int i = 0; i < DEPTH + 1; i++) begin
            record_sample(rnd_sample());
            tick(5);
        end
        tick(2);
        check("full_flag", full, 1);
        check("full_len", rec_len, DEPTH);
        check("full_state", state, 0);

        // playback, then reset in the middle of a read
        do_play();
        tick(2);
        for (int i = 0; i < 3; i++) begin
            play_request();
            tick(8);
        end
        check("play_third", dac_data, model_mem[2]);
        pulse_dac();
        check("rd_in_progress", {sram_ce_n, sram_oe_n}, 2'b00);
        reset = 1'b1;
        tick(1);
        check("mid_rd_reset_strobes", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b1110);
        check("mid_rd_reset_dac", dac_data, 0);
        check("mid_rd_reset_state", state, 0);
        tick(1);
        reset = 1'b0;
        model_len = 0; model_playing = 0; model_recording = 0;
        tick(2);
        check("post_reset_len", rec_len, 0);

        tick(4);
        check("wr_q_empty", exp_wr_q.size(), 0);
        check("rd_q_empty", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sram_ctrl.md
Name: audio_sram_ctrl

Overview:
- Sequences the shared audio sample SRAM between the ADC capture path (record) and the DAC playback path (play), one mode at a time.
- Turns ADC sample-valid pulses into timed SRAM write cycles at incrementing addresses, and turns DAC frame requests into timed SRAM read cycles.
- Tracks recording length, full and overrun status.
- Sits between the ADC/DAC serial blocks and the external SRAM pins; runs entirely in the bclk domain.

Parameters:
- ADDR_W, 18, SRAM word-address width; maximum address is 2^ADDR_W-1.
- DATA_W, 16, sample and SRAM word width.
- WR_CYCLES, 2, cycles with we_n low per write (minimum 1).
- RD_CYCLES, 2, cycles with oe_n low per read; data is sampled on the last of these cycles (minimum 1).

Ports:
- bclk  in  1  audio bit clock, sole clock.
- reset  in  1  synchronous, active-high.
- cmd_record  in  1  one-cycle pulse: start a new recording at address 0.
- cmd_play  in  1  one-cycle pulse: start playback at address 0.
- cmd_pause  in  1  one-cycle pulse: toggle pause.
- cmd_stop  in  1  one-cycle pulse: return to IDLE.
- adc_valid  in  1  one-cycle pulse; a new sample is present on adc_data.
- adc_data  in  DATA_W  ADC sample.
- dac_req  in  1  one-cycle pulse; the DAC needs the next sample.
- dac_data  out  DATA_W  sample for the DAC; holds between updates.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_out  out  DATA_W  write data.
- sram_dq_oe  out  1  enables the top-level tristate driver.
- sram_dq_in  in  DATA_W  read data.
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  active-low SRAM strobes.
- state  out  3  current FSM state encoding (debug/LEDs).
- rec_len  out  ADDR_W+1  number of samples recorded.
- full  out  1  sticky; recording reached the maximum address.
- overrun  out  1  sticky; a sample was dropped during a write.

Behaviour:
- Reset values: state IDLE; addr 0; rec_len 0; dac_data 0; sram_ce_n, sram_we_n and sram_oe_n all 1; sram_dq_oe 0; full 0; overrun 0; pause_pending and stop_pending 0.
- Reset mid-access aborts immediately; all strobes are high at the next edge.
- States: IDLE(0), REC_WAIT(1), REC_WR(2), PLAY_WAIT(3), PLAY_RD(4), PAUSE(5).
- Simultaneous commands: priority is stop > pause > play > record.
- IDLE + cmd_record: addr<=0, rec_len<=0, full<=0, overrun<=0; go to REC_WAIT.
- IDLE + cmd_play: if rec_len!=0, addr<=0 and go to PLAY_WAIT. If rec_len==0 the command is ignored.
- REC_WAIT + adc_valid: latch adc_data into sram_dq_out and go to REC_WR.
- REC_WR: ce_n=0, dq_oe=1, we_n=0 for exactly WR_CYCLES cycles, with address and data stable throughout. On the final cycle:
  - rec_len<=addr+1.
  - If addr==max: full<=1, go to IDLE.
  - Otherwise addr<=addr+1 and go to REC_WAIT.
- adc_valid arriving in REC_WR: the sample is dropped and overrun<=1.
- PLAY_WAIT + dac_req: go to PLAY_RD.
- PLAY_RD: ce_n=0, oe_n=0 for RD_CYCLES cycles. On the last cycle dac_data<=sram_dq_in, which is visible the cycle after. Then:
  - If addr+1==rec_len: end of recording (see Optional Feature).
  - Otherwise addr<=addr+1 and go to PLAY_WAIT.
- dac_req arriving in PLAY_RD: ignored; dac_data repeats the previous sample.
- cmd_pause in REC_WAIT or PLAY_WAIT: go to PAUSE and record the originating mode in a resume bit.
- cmd_pause in PAUSE: return to the saved WAIT state with addr unchanged.
- cmd_pause during REC_WR or PLAY_RD: sets pause_pending. The access completes, then the FSM goes to PAUSE instead of WAIT.
- cmd_stop from any non-IDLE state goes to IDLE:
  - During REC_WR or PLAY_RD it sets stop_pending; the access completes first. An SRAM cycle is never truncated.
  - Stopping a recording leaves rec_len equal to the number of samples written.
- dac_data is forced to 0 on entry to IDLE or PAUSE from the play path.
- In IDLE and PAUSE, adc_valid and dac_req are ignored; in PAUSE, cmd_record and cmd_play are also ignored.
- The strobes are registered outputs: glitch-free, and no strobe is low outside REC_WR or PLAY_RD.

Optional Feature:
- Macro: AUDIO_SRAM_CTRL_LOOP_EN.
- Defined: on end of recording in PLAY_RD, addr<=0 and go to PLAY_WAIT; playback loops until stop or pause.
- Undefined: on end of recording, go to IDLE, dac_data<=0.

Decomposition:
- Shared package audio_pkg holds the FSM state enum/localparams, ADDR_W and DATA_W defaults, and the MAX_ADDR constant.
- One sub-module, sram_access_timer: a down-counter loaded with WR_CYCLES or RD_CYCLES that emits a last_cycle pulse. It is used by both the REC_WR and PLAY_RD states.

Test Plan:
- Record, then stop: reset, cmd_record, 5 adc_valid pulses of 0x1111..0x5555 spaced 64 cycles apart, cmd_stop. Expect SRAM[0..4] to hold those values, we_n low for 2 cycles per write, rec_len=5, state=IDLE.
- Playback: after the record test, cmd_play and 6 dac_req pulses. Expect dac_data=0x1111..0x5555, one sample per request, oe_n low for 2 cycles each. After the 5th read: macro undefined gives IDLE with dac_data=0; macro defined gives 0x1111 on the 6th request.
- Pause mid-write: cmd_pause issued during REC_WR. Expect the write to complete, state=PAUSE, addr+1 retained; a second cmd_pause resumes and the next sample lands at the following address.
- Overrun and empty play: a second adc_valid pulse 1 cycle after the first must drop the sample and set overrun=1. cmd_play with rec_len=0 must leave state IDLE.
- Full: ADDR_W=4, 17 samples recorded. Expect full=1 after sample 16, rec_len=16, state IDLE; the 17th sample is ignored.
- Reset mid-read: assert reset during PLAY_RD. Expect all strobes high and dac_data=0 on the next edge.
